// File: rtl/sc1_uart_loader.sv
// UART boot loader for sc1_soc: receives an A5-framed, length-prefixed, XOR-checksummed
// image over 8N1 serial and writes it word by word into instruction memory.
module sc1_uart_loader #(
    parameter int UART_CLK_HZ        = 12000000,
    parameter int UART_SCLK_HZ       = 115200,
    parameter int UART_COUNTER_WIDTH = 9,
    parameter int WIDTH_D            = 32,
    parameter int DEPTH_I            = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               uart_rxd,
    output logic               mem_we,
    output logic [DEPTH_I-1:0] mem_addr,
    output logic [WIDTH_D-1:0] mem_data,
    output logic               cpu_reset,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int DIV = UART_CLK_HZ / UART_SCLK_HZ;
    localparam logic [UART_COUNTER_WIDTH-1:0] BIT_M1  = UART_COUNTER_WIDTH'(DIV - 1);
    localparam logic [UART_COUNTER_WIDTH-1:0] HALF_M1 = UART_COUNTER_WIDTH'(DIV / 2 - 1);
    localparam logic [16:0] MAX_WORDS = 17'(1 << DEPTH_I);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

    logic rst_meta, rst_n_s;

    // Asynchronous assertion, release aligned to clk after two flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta <= 1'b0;
            rst_n_s  <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n_s  <= rst_meta;
        end
    end

    logic rxd_p0, rxd_p1, rxd_p2;

    // Stage p0/p1: synchronizer; p2 holds the previous synchronized value for edge detection
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            rxd_p2 <= 1'b1;
        end else begin
            rxd_p0 <= uart_rxd;
            rxd_p1 <= rxd_p0;
            rxd_p2 <= rxd_p1;
        end
    end

    rx_state_t                     rx_state;
    logic [UART_COUNTER_WIDTH-1:0] rx_cnt;
    logic [2:0]                    rx_bit;
    logic [7:0]                    rx_shift;
    logic [7:0]                    rx_byte;
    logic                          byte_valid;
    logic                          frame_err;

    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rxd_p2 && !rxd_p1) begin
                        rx_cnt   <= HALF_M1;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else if (rxd_p1) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt   <= BIT_M1;
                        rx_bit   <= '0;
                        rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        rx_shift <= {rxd_p1, rx_shift[7:1]};
                        rx_cnt   <= BIT_M1;
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        if (rxd_p1) begin
                            rx_byte    <= rx_shift;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    state_t             state;
    logic [15:0]        count;
    logic [16:0]        words_done;
    logic [1:0]         byte_idx;
    logic [7:0]         checksum;
    logic [WIDTH_D-1:0] word;
    logic [16:0]        len_next;

    assign len_next = {1'b0, rx_byte, count[7:0]};

    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state      <= IDLE;
            count      <= '0;
            words_done <= '0;
            byte_idx   <= '0;
            checksum   <= '0;
            word       <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (mem_we) mem_addr <= mem_addr + DEPTH_I'(1);
            case (state)
                IDLE, DONE, ERR: begin
                    if (byte_valid && rx_byte == SYNC_BYTE) begin
                        state      <= LEN0;
                        busy       <= 1'b1;
                        cpu_reset  <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        mem_addr   <= '0;
                        checksum   <= '0;
                        words_done <= '0;
                        byte_idx   <= '0;
                    end
                end
                LEN0: begin
                    if (byte_valid) begin
                        count[7:0] <= rx_byte;
                        state      <= LEN1;
                    end else if (frame_err) begin
                        state <= ERR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                LEN1: begin
                    if (byte_valid) begin
                        count[15:8] <= rx_byte;
                        if (len_next == 17'd0) begin
                            state <= CSUM;
                        end else if (len_next > MAX_WORDS) begin
                            state <= ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end else if (frame_err) begin
                        state <= ERR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                DATA: begin
                    // Leave DATA on the cycle the final write strobe is visible
                    if (mem_we) begin
                        words_done <= words_done + 17'd1;
                        if (words_done + 17'd1 == {1'b0, count}) state <= CSUM;
                    end
                    if (byte_valid) begin
                        checksum                <= checksum ^ rx_byte;
                        word[{byte_idx, 3'b000} +: 8] <= rx_byte;
                        byte_idx                <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we   <= 1'b1;
                            mem_data <= WIDTH_D'({rx_byte, word[23:0]});
                        end
                    end else if (frame_err) begin
                        state <= ERR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                CSUM: begin
                    if (byte_valid) begin
                        busy <= 1'b0;
                        if (rx_byte == checksum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end else if (frame_err) begin
                        state <= ERR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sc1_uart_loader.sv
// Bench for sc1_uart_loader: directed and random loads over the serial line, memory
// writes checked by a scoreboard fed from a byte-level model of the load protocol.
module tb_sc1_uart_loader;

    localparam int CLK_HZ  = 1_600_000;
    localparam int SCLK_HZ = 100_000;
    localparam int DIV     = CLK_HZ / SCLK_HZ;
    localparam int DEPTH   = 10;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             uart_rxd = 1'b1;
    logic             mem_we;
    logic [DEPTH-1:0] mem_addr;
    logic [31:0]      mem_data;
    logic             cpu_reset, busy, done, error;

    sc1_uart_loader #(
        .UART_CLK_HZ(CLK_HZ), .UART_SCLK_HZ(SCLK_HZ), .UART_COUNTER_WIDTH(9),
        .WIDTH_D(32), .DEPTH_I(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .uart_rxd(uart_rxd), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data(mem_data), .cpu_reset(cpu_reset),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DEPTH-1:0] addr;
        logic [31:0]      data;
    } wr_t;

    int         vectors = 0;
    int         miscompares = 0;
    wr_t        exp_q[$];
    logic [7:0] stim[$];

    // Write monitor: every strobe must match the next expected write
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_data !== e.data) begin
                    miscompares++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr, mem_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input bit b, input bit d, input bit e, input bit c);
        check({tag, "_busy"}, 64'(busy), 64'(b));
        check({tag, "_done"}, 64'(done), 64'(d));
        check({tag, "_error"}, 64'(error), 64'(e));
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(c));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rxd = stop_ok;
        repeat (DIV) @(negedge clk);
        uart_rxd = 1'b1;
        if (!stop_ok) repeat (DIV) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_stim();
        foreach (stim[i]) send_byte(stim[i], 1'b1);
    endtask

    // Reference: parse the byte stream as a load and predict writes and final outcome
    task automatic model_load(output bit exp_done, output bit exp_err);
        int         cnt;
        logic [7:0] cs;
        logic [31:0] w;
        wr_t        x;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        cnt = int'(stim[1]) + 256 * int'(stim[2]);
        if (cnt > (1 << DEPTH)) begin
            exp_err = 1'b1;
            return;
        end
        cs = 8'h00;
        for (int k = 0; k < cnt; k++) begin
            w = {stim[3+4*k+3], stim[3+4*k+2], stim[3+4*k+1], stim[3+4*k]};
            cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            x.addr = DEPTH'(k % (1 << DEPTH));
            x.data = w;
            exp_q.push_back(x);
        end
        if (stim[3+4*cnt] == cs) exp_done = 1'b1;
        else                     exp_err  = 1'b1;
    endtask

    task automatic run_load(input string tag);
        bit ed, ee;
        model_load(ed, ee);
        send_stim();
        if (ed) check_status(tag, 1'b0, 1'b1, 1'b0, 1'b0);
        else    check_status(tag, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic build_load(input int cnt, input bit good_csum);
        logic [7:0] cs, b;
        stim.delete();
        stim.push_back(8'hA5);
        stim.push_back(cnt[7:0]);
        stim.push_back(cnt[15:8]);
        if (cnt > (1 << DEPTH)) return;
        cs = 8'h00;
        for (int k = 0; k < 4 * cnt; k++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
            cs ^= b;
            stim.push_back(b);
        end
        if (!good_csum) cs ^= 8'($urandom_range(1, 255));
        stim.push_back(cs);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_data"}, 64'(mem_data), 64'd0);
        check_status(tag, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        send_byte(8'h55, 1'b1);
        check_status("garbage_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        stim = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        run_load("two_words");

        stim = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        run_load("bad_csum");

        stim = '{8'hA5, 8'h01, 8'h04};
        run_load("too_long");

        stim = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_load("zero_len");
        send_byte(8'hA5, 1'b1);
        check_status("resync", 1'b1, 1'b0, 1'b0, 1'b1);

        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        check_status("framing", 1'b0, 1'b0, 1'b1, 1'b1);
        send_byte(8'h55, 1'b1);
        check_status("garbage_err", 1'b0, 1'b0, 1'b1, 1'b1);

        build_load(2, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(stim[i], 1'b1);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("mid_reset");
        reset_n = 1'b1;
        repeat (5 * DIV) @(negedge clk);
        check_reset_values("after_reset");
        run_load("reload");

        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(0, 2) == 0) send_byte(8'($urandom_range(0, 8'hA4)), 1'b1);
            cnt = ($urandom_range(0, 5) == 0) ? 1025 + int'($urandom_range(0, 3000))
                                              : int'($urandom_range(0, 4));
            build_load(cnt, $urandom_range(0, 3) != 0);
            run_load("random");
        end

        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        check("pending_writes", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
